// File: rtl/cpu_pkg.sv
// cpu_pkg: shared forwarding encodings, operand-unused marker and MDU latencies
package cpu_pkg;
  typedef enum logic [1:0] {FW_NONE = 2'd0, FW_FAR = 2'd1, FW_NEAR = 2'd2} fw_sel_e;
  localparam logic [1:0] TUSE_NONE = 2'b11;
  localparam int MD_MULT_LAT = 5;
  localparam int MD_DIV_LAT = 10;
endpackage

// File: rtl/hazard_ctrl_unit_md_if.sv
// hazard_ctrl_unit_md_if: pipeline-to-hazard-unit bundle of addresses, timing fields and selects
interface hazard_ctrl_unit_md_if #(parameter int REG_AW = 5, parameter int TW = 2);
  logic [REG_AW-1:0] D_ra1, D_ra2, E_ra1, E_ra2, M_ra2, E_wa, M_wa, W_wa;
  logic E_we, M_we, W_we;
  logic [TW-1:0] Tuse_rs, Tuse_rt, Tnew_E, Tnew_M, Tnew_W;
  logic D_is_md, E_md_start, E_md_is_div;
  logic [1:0] fw_cmp1_D, fw_cmp2_D, fw_alu_a_E, fw_alu_b_E;
  logic fw_dm_M, stall, md_busy;
  modport master(
    output D_ra1, D_ra2, E_ra1, E_ra2, M_ra2, E_wa, M_wa, W_wa, E_we, M_we, W_we,
    output Tuse_rs, Tuse_rt, Tnew_E, Tnew_M, Tnew_W, D_is_md, E_md_start, E_md_is_div,
    input fw_cmp1_D, fw_cmp2_D, fw_alu_a_E, fw_alu_b_E, fw_dm_M, stall, md_busy
  );
  modport slave(
    input D_ra1, D_ra2, E_ra1, E_ra2, M_ra2, E_wa, M_wa, W_wa, E_we, M_we, W_we,
    input Tuse_rs, Tuse_rt, Tnew_E, Tnew_M, Tnew_W, D_is_md, E_md_start, E_md_is_div,
    output fw_cmp1_D, fw_cmp2_D, fw_alu_a_E, fw_alu_b_E, fw_dm_M, stall, md_busy
  );
endinterface

// File: rtl/md_busy_ctr.sv
// md_busy_ctr: MDU iteration countdown, loaded on start with the mult or div latency
module md_busy_ctr import cpu_pkg::*; #(
  parameter int MULT_LAT = MD_MULT_LAT,
  parameter int DIV_LAT = MD_DIV_LAT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic is_div,
  output logic busy
);
  localparam int CW = $clog2(DIV_LAT + 1);
  logic [CW-1:0] cnt, cnt_nxt;
  // a start always reloads, even mid-iteration
  always_comb cnt_nxt = start ? (is_div ? CW'(DIV_LAT) : CW'(MULT_LAT)) : cnt - CW'(busy);
  always_ff @(posedge clk) cnt <= reset_n ? cnt_nxt : '0;
  assign busy = cnt != '0;
endmodule

// File: rtl/hazard_ctrl_unit_md.sv
// hazard_ctrl_unit_md: Tuse/Tnew forwarding and stall control with MDU busy tracking; HAZ_STAT_EN adds stall counters
module hazard_ctrl_unit_md import cpu_pkg::*; #(
  parameter int REG_AW = 5,
  parameter int TW = 2,
  parameter int MULT_LAT = MD_MULT_LAT,
  parameter int DIV_LAT = MD_DIV_LAT
) (
  input  logic clk,
  input  logic reset_n,
`ifdef HAZ_STAT_EN
  output logic [31:0] stat_data_stalls,
  output logic [31:0] stat_md_stalls,
`endif
  hazard_ctrl_unit_md_if.slave hif
);
  function automatic logic hit(logic [REG_AW-1:0] r, logic [REG_AW-1:0] wa, logic we);
    return we && r == wa && r != '0;
  endfunction
  function automatic logic ready(logic h, logic [TW-1:0] tnew);
    return h && tnew == '0;
  endfunction
  function automatic logic [1:0] fw(logic near, logic far);
    return near ? FW_NEAR : far ? FW_FAR : FW_NONE;
  endfunction
  // an unused operand carries Tuse all-ones, which no Tnew can exceed
  function automatic logic late(logic h, logic [TW-1:0] tuse, logic [TW-1:0] tnew);
    return h && tuse < tnew;
  endfunction
  logic e1, e2, m1, m2, data_stall, md_stall, md_busy;
  assign e1 = hit(hif.D_ra1, hif.E_wa, hif.E_we);
  assign e2 = hit(hif.D_ra2, hif.E_wa, hif.E_we);
  assign m1 = hit(hif.D_ra1, hif.M_wa, hif.M_we);
  assign m2 = hit(hif.D_ra2, hif.M_wa, hif.M_we);
  assign hif.fw_cmp1_D = fw(ready(e1, hif.Tnew_E), ready(m1, hif.Tnew_M));
  assign hif.fw_cmp2_D = fw(ready(e2, hif.Tnew_E), ready(m2, hif.Tnew_M));
  assign hif.fw_alu_a_E = fw(ready(hit(hif.E_ra1, hif.M_wa, hif.M_we), hif.Tnew_M),
                             ready(hit(hif.E_ra1, hif.W_wa, hif.W_we), hif.Tnew_W));
  assign hif.fw_alu_b_E = fw(ready(hit(hif.E_ra2, hif.M_wa, hif.M_we), hif.Tnew_M),
                             ready(hit(hif.E_ra2, hif.W_wa, hif.W_we), hif.Tnew_W));
  assign hif.fw_dm_M = ready(hit(hif.M_ra2, hif.W_wa, hif.W_we), hif.Tnew_W);
  assign data_stall = late(e1, hif.Tuse_rs, hif.Tnew_E) || late(m1, hif.Tuse_rs, hif.Tnew_M) ||
                      late(e2, hif.Tuse_rt, hif.Tnew_E) || late(m2, hif.Tuse_rt, hif.Tnew_M);
  assign md_stall = hif.D_is_md && (hif.E_md_start || md_busy);
  assign hif.stall = data_stall || md_stall;
  assign hif.md_busy = md_busy;
  md_busy_ctr #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) u_md (
    .clk(clk),
    .reset_n(reset_n),
    .start(hif.E_md_start),
    .is_div(hif.E_md_is_div),
    .busy(md_busy)
  );
`ifdef HAZ_STAT_EN
  always_ff @(posedge clk)
    if (!reset_n) begin
      stat_data_stalls <= '0;
      stat_md_stalls <= '0;
    end else begin
      stat_data_stalls <= stat_data_stalls + 32'(data_stall);
      stat_md_stalls <= stat_md_stalls + 32'(md_stall);
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl_unit_md.sv
// tb_hazard_ctrl_unit_md: directed and random checks against a stage-list reference model; HAZ_STAT_EN checks counters
module tb_hazard_ctrl_unit_md;
  import cpu_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int edges = 0;
  int busy_end = 0;
  hazard_ctrl_unit_md_if hif ();
`ifdef HAZ_STAT_EN
  logic [31:0] stat_data_stalls, stat_md_stalls;
  logic [31:0] mdl_data = 0, mdl_md = 0;
`endif
  hazard_ctrl_unit_md dut (
    .clk(clk),
    .reset_n(reset_n),
`ifdef HAZ_STAT_EN
    .stat_data_stalls(stat_data_stalls),
    .stat_md_stalls(stat_md_stalls),
`endif
    .hif(hif)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // producer stages indexed 0 = E, 1 = M, 2 = W
  function automatic logic produces(int s, logic [4:0] r);
    logic [4:0] wa [3];
    logic we [3];
    wa[0] = hif.E_wa; wa[1] = hif.M_wa; wa[2] = hif.W_wa;
    we[0] = hif.E_we; we[1] = hif.M_we; we[2] = hif.W_we;
    return r != 5'd0 && r == wa[s] && we[s];
  endfunction
  function automatic int tnew_of(int s);
    return s == 0 ? int'(hif.Tnew_E) : s == 1 ? int'(hif.Tnew_M) : int'(hif.Tnew_W);
  endfunction
  function automatic int ready_stage(logic [4:0] r, int lo, int hi);
    for (int s = lo; s <= hi; s++)
      if (produces(s, r) && tnew_of(s) == 0) return s;
    return -1;
  endfunction
  function automatic logic [1:0] sel(int s, int lo);
    return s < 0 ? 2'd0 : (s == lo ? 2'd2 : 2'd1);
  endfunction
  function automatic logic must_wait(logic [4:0] r, logic [1:0] tuse);
    for (int s = 0; s <= 1; s++)
      if (produces(s, r) && int'(tuse) < tnew_of(s)) return 1'b1;
    return 1'b0;
  endfunction
  function automatic logic mdl_busy();
    return edges < busy_end;
  endfunction
  function automatic logic exp_data();
    return must_wait(hif.D_ra1, hif.Tuse_rs) || must_wait(hif.D_ra2, hif.Tuse_rt);
  endfunction
  function automatic logic exp_md();
    return hif.D_is_md && (hif.E_md_start || mdl_busy());
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_all();
    #1;
    chk("fw_cmp1_D", 32'(hif.fw_cmp1_D), 32'(sel(ready_stage(hif.D_ra1, 0, 1), 0)));
    chk("fw_cmp2_D", 32'(hif.fw_cmp2_D), 32'(sel(ready_stage(hif.D_ra2, 0, 1), 0)));
    chk("fw_alu_a_E", 32'(hif.fw_alu_a_E), 32'(sel(ready_stage(hif.E_ra1, 1, 2), 1)));
    chk("fw_alu_b_E", 32'(hif.fw_alu_b_E), 32'(sel(ready_stage(hif.E_ra2, 1, 2), 1)));
    chk("fw_dm_M", 32'(hif.fw_dm_M), 32'(ready_stage(hif.M_ra2, 2, 2) >= 0));
    chk("stall", 32'(hif.stall), 32'(exp_data() || exp_md()));
    chk("md_busy", 32'(hif.md_busy), 32'(mdl_busy()));
`ifdef HAZ_STAT_EN
    chk("stat_data", stat_data_stalls, mdl_data);
    chk("stat_md", stat_md_stalls, mdl_md);
`endif
  endtask
  task automatic tick();
    logic d, m;
    d = exp_data();
    m = exp_md();
    if (!reset_n) busy_end = 0;
    else if (hif.E_md_start) busy_end = edges + 1 + (hif.E_md_is_div ? MD_DIV_LAT : MD_MULT_LAT);
`ifdef HAZ_STAT_EN
    mdl_data = reset_n ? mdl_data + 32'(d) : 0;
    mdl_md = reset_n ? mdl_md + 32'(m) : 0;
`endif
    @(posedge clk);
    edges++;
    #1;
  endtask
  task automatic idle();
    {hif.D_ra1, hif.D_ra2, hif.E_ra1, hif.E_ra2, hif.M_ra2} = '0;
    {hif.E_wa, hif.M_wa, hif.W_wa, hif.E_we, hif.M_we, hif.W_we} = '0;
    hif.Tuse_rs = TUSE_NONE;
    hif.Tuse_rt = TUSE_NONE;
    {hif.Tnew_E, hif.Tnew_M, hif.Tnew_W} = '0;
    {hif.D_is_md, hif.E_md_start, hif.E_md_is_div} = '0;
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    #1 chk("reset_busy", 32'(hif.md_busy), 32'd0);
    chk("reset_stall", 32'(hif.stall), 32'd0);
    chk_all();
    // lw $3 followed by beq on $3
    hif.E_wa = 5'd3; hif.E_we = 1'b1; hif.Tnew_E = 2'd2; hif.D_ra1 = 5'd3; hif.Tuse_rs = 2'd0;
    #1 chk("lw_E_stall", 32'(hif.stall), 32'd1);
    chk_all();
    tick();
    hif.E_we = 1'b0; hif.E_wa = 5'd0; hif.M_wa = 5'd3; hif.M_we = 1'b1; hif.Tnew_M = 2'd1;
    #1 chk("lw_M_stall", 32'(hif.stall), 32'd1);
    chk_all();
    tick();
    hif.M_we = 1'b0; hif.M_wa = 5'd0; hif.W_wa = 5'd3; hif.W_we = 1'b1; hif.Tnew_W = 2'd0;
    #1 chk("lw_W_stall", 32'(hif.stall), 32'd0);
    chk("lw_W_fw", 32'(hif.fw_cmp1_D), 32'd0);
    chk_all();
    tick();
    // M-over-W priority and $0 never forwarded
    idle();
    hif.M_wa = 5'd5; hif.M_we = 1'b1; hif.W_wa = 5'd5; hif.W_we = 1'b1; hif.E_ra1 = 5'd5;
    hif.E_wa = 5'd0; hif.E_we = 1'b1; hif.D_ra1 = 5'd0; hif.Tuse_rs = 2'd0; hif.Tnew_E = 2'd2;
    #1 chk("alu_a_prio", 32'(hif.fw_alu_a_E), 32'd2);
    chk("zero_fw", 32'(hif.fw_cmp1_D), 32'd0);
    chk("zero_stall", 32'(hif.stall), 32'd0);
    chk_all();
    tick();
    // unused rt and store-data forwarding
    idle();
    hif.D_ra2 = 5'd4; hif.E_wa = 5'd4; hif.E_we = 1'b1; hif.Tnew_E = 2'd2; hif.Tuse_rt = TUSE_NONE;
    hif.M_ra2 = 5'd7; hif.W_wa = 5'd7; hif.W_we = 1'b1; hif.Tnew_W = 2'd0;
    #1 chk("tuse_none", 32'(hif.stall), 32'd0);
    chk("dm_fw", 32'(hif.fw_dm_M), 32'd1);
    chk_all();
    tick();
    // mult: 1 start cycle + 5 busy cycles of md stall
    idle();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    hif.D_is_md = 1'b1; hif.E_md_start = 1'b1;
    #1 chk("mult_start_stall", 32'(hif.stall), 32'd1);
    chk_all();
    tick();
    hif.E_md_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("mult_busy", 32'(hif.md_busy), 32'd1);
      chk("mult_stall", 32'(hif.stall), 32'd1);
      chk_all();
      tick();
    end
    chk("mult_done_busy", 32'(hif.md_busy), 32'd0);
    chk("mult_done_stall", 32'(hif.stall), 32'd0);
    chk_all();
`ifdef HAZ_STAT_EN
    chk("stat_md_6", stat_md_stalls, 32'd6);
    chk("stat_data_0", stat_data_stalls, 32'd0);
    reset_n = 1'b0;
    tick();
    chk("stat_md_rst", stat_md_stalls, 32'd0);
    chk("stat_data_rst", stat_data_stalls, 32'd0);
    reset_n = 1'b1;
`endif
    // div interrupted by reset at busy cycle 4
    hif.E_md_start = 1'b1; hif.E_md_is_div = 1'b1;
    tick();
    hif.E_md_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("div_busy", 32'(hif.md_busy), 32'd1);
      chk_all();
      tick();
    end
    chk("div_busy4", 32'(hif.md_busy), 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1 chk("div_rst_busy", 32'(hif.md_busy), 32'd0);
    chk("div_rst_stall", 32'(hif.stall), 32'd0);
    chk_all();
    tick();
    // random traffic over a small register window to provoke hits
    for (int n = 0; n < 400; n++) begin
      hif.D_ra1 = 5'($urandom_range(0, 7)); hif.D_ra2 = 5'($urandom_range(0, 7));
      hif.E_ra1 = 5'($urandom_range(0, 7)); hif.E_ra2 = 5'($urandom_range(0, 7));
      hif.M_ra2 = 5'($urandom_range(0, 7));
      hif.E_wa = 5'($urandom_range(0, 7)); hif.M_wa = 5'($urandom_range(0, 7));
      hif.W_wa = 5'($urandom_range(0, 7));
      hif.E_we = 1'($urandom); hif.M_we = 1'($urandom); hif.W_we = 1'($urandom);
      hif.Tuse_rs = 2'($urandom); hif.Tuse_rt = 2'($urandom);
      hif.Tnew_E = 2'($urandom); hif.Tnew_M = 2'($urandom); hif.Tnew_W = 2'($urandom);
      hif.D_is_md = 1'($urandom);
      hif.E_md_start = $urandom_range(0, 7) == 0;
      hif.E_md_is_div = 1'($urandom);
      reset_n = $urandom_range(0, 29) != 0;
      chk_all();
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
